// File: rtl/i2s_pkg.sv
// Shared I2S types: slot/frame geometry and the sample-to-frame packer.
// Samples are left-justified in 32-bit slots; the frame is {left, right}.
package i2s_pkg;

    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 64;

    typedef logic [FRAME_BITS-1:0] frame_t;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Samples arrive right-aligned; shift them up so padding lands on the LSBs.
    function automatic frame_t pack_frame(
        input logic [SLOT_BITS-1:0] left,
        input logic [SLOT_BITS-1:0] right,
        input int                   width
    );
        int pad;
        pad = SLOT_BITS - width;
        return {left << pad, right << pad};
    endfunction

endpackage

// File: rtl/i2s_clk_en.sv
// BCK generator: clock-enable divider giving a BCK level plus edge strobes.
// Strobes are asserted in the cycle before BCK changes, so users update with it.
module i2s_clk_en #(
    parameter int CLK_DIV = 40
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bck,
    output logic bck_rise,
    output logic bck_fall
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    if (CLK_DIV < 2) begin : g_div_check
        $error("i2s_clk_en: CLK_DIV must be at least 2");
    end

    logic [DW-1:0] div_cnt;
    logic          wrap;

    assign wrap     = run && (div_cnt == LAST);
    assign bck_rise = wrap && !bck;
    assign bck_fall = wrap && bck;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            bck     <= 1'b0;
        end else if (!run) begin
            div_cnt <= '0;
            bck     <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            bck     <= !bck;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_tx_pcm5102.sv
// I2S transmitter for the PCM5102: one holding register, a 64-bit shifter,
// BCK/LRCK by clock-enable division, silent until the PLL reports lock.
module i2s_tx_pcm5102
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 24,
    parameter int CLK_DIV      = 40
) (
    input  logic                    clock_in,
    input  logic                    reset,
    input  logic                    locked,
    input  logic [SAMPLE_WIDTH-1:0] sample_left,
    input  logic [SAMPLE_WIDTH-1:0] sample_right,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic                    i2s_bck,
    output logic                    i2s_lrck,
    output logic                    i2s_data,
    output logic                    frame_start,
    output logic                    underrun
);

    if (SAMPLE_WIDTH < 16 || SAMPLE_WIDTH > SLOT_BITS) begin : g_width_check
        $error("i2s_tx_pcm5102: SAMPLE_WIDTH must be within 16..32");
    end

    state_t     state;
    frame_t     hold;
    logic       full;
    frame_t     shifter;
    logic [5:0] bit_cnt;
    logic [5:0] bit_cnt_nxt;
    logic       run;
    logic       bck_fall;
    logic       bck_rise_unused;
    logic       accept;
    logic       load;

    assign run          = (state == RUN) && locked;
    assign sample_ready = (state == RUN) && !full;
    assign accept       = sample_valid && sample_ready;
    assign bit_cnt_nxt  = bit_cnt + 6'd1;
    assign load         = bck_fall && (bit_cnt == 6'd63);

    i2s_clk_en #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_en (
        .clk     (clock_in),
        .rst     (reset),
        .run     (run),
        .bck     (i2s_bck),
        .bck_rise(bck_rise_unused),
        .bck_fall(bck_fall)
    );

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            hold        <= '0;
            full        <= 1'b0;
            shifter     <= '0;
            bit_cnt     <= '0;
            i2s_lrck    <= 1'b0;
            i2s_data    <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else if (!locked || state == IDLE) begin
            // Lock loss flushes everything; lock entry starts from a clean slate.
            state       <= locked ? RUN : IDLE;
            hold        <= '0;
            full        <= 1'b0;
            shifter     <= '0;
            bit_cnt     <= '0;
            i2s_lrck    <= 1'b0;
            i2s_data    <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            if (accept) begin
                hold <= pack_frame(32'(sample_left), 32'(sample_right),
                                   SAMPLE_WIDTH);
                full <= 1'b1;
            end else if (load) begin
                full <= 1'b0;
            end
            if (bck_fall) begin
                bit_cnt  <= bit_cnt_nxt;
                i2s_lrck <= bit_cnt_nxt[5];
                // MSB of the shifter goes out one BCK after LRCK changes.
                i2s_data <= shifter[FRAME_BITS-1];
                if (load) begin
                    shifter     <= full ? hold : '0;
                    frame_start <= 1'b1;
                    underrun    <= !full;
                end else begin
                    shifter <= shifter << 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_pcm5102.sv
// Randomised bench for i2s_tx_pcm5102 against a cycle-count model of the
// I2S timing: BCK, bit index and frame contents derived from elapsed cycles.
module tb_i2s_tx_pcm5102;

    localparam int CLK_DIV = 2;
    localparam int SW      = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic          locked;
    logic [SW-1:0] sl;
    logic [SW-1:0] sr;
    logic          valid;
    logic          ready;
    logic          bck;
    logic          lrck;
    logic          data;
    logic          fs;
    logic          ur;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    i2s_tx_pcm5102 #(
        .SAMPLE_WIDTH(SW),
        .CLK_DIV     (CLK_DIV)
    ) dut (
        .clock_in    (clk),
        .reset       (reset),
        .locked      (locked),
        .sample_left (sl),
        .sample_right(sr),
        .sample_valid(valid),
        .sample_ready(ready),
        .i2s_bck     (bck),
        .i2s_lrck    (lrck),
        .i2s_data    (data),
        .frame_start (fs),
        .underrun    (ur)
    );

    // ---------------- behavioural model ----------------
    bit          running = 1'b0;
    int          n = 0;
    bit          pend_full = 1'b0;
    logic [63:0] pend = '0;
    logic [63:0] frames[$];
    bit          m_fs = 1'b0;
    bit          m_ur = 1'b0;

    function automatic int falls_at(input int cycles);
        return (cycles / CLK_DIV) / 2;
    endfunction

    function automatic int model_k();
        return falls_at(n) % 64;
    endfunction

    task automatic model_clear();
        n         = 0;
        pend_full = 1'b0;
        pend      = '0;
        frames.delete();
        frames.push_back(64'h0);
        m_fs      = 1'b0;
        m_ur      = 1'b0;
    endtask

    always @(posedge clk or posedge reset) begin
        bit acc_m;
        int fo;
        int fnw;
        if (reset) begin
            running = 1'b0;
            model_clear();
        end else if (!locked) begin
            running = 1'b0;
            model_clear();
        end else if (!running) begin
            running = 1'b1;
            model_clear();
        end else begin
            acc_m = valid && !pend_full;
            n++;
            fo   = falls_at(n - 1);
            fnw  = falls_at(n);
            m_fs = 1'b0;
            m_ur = 1'b0;
            if (fnw != fo && fnw % 64 == 0) begin
                if (pend_full) begin
                    frames.push_back(pend);
                end else begin
                    frames.push_back(64'h0);
                    m_ur = 1'b1;
                end
                m_fs      = 1'b1;
                pend_full = 1'b0;
            end
            if (acc_m) begin
                pend      = {sl, 8'h00, sr, 8'h00};
                pend_full = 1'b1;
            end
        end
    end

    function automatic logic [5:0] expect_out();
        int   m;
        int   k;
        logic d;
        if (!running) return 6'b0;
        m = falls_at(n);
        k = m % 64;
        d = (m == 0) ? 1'b0 : frames[(m - 1) / 64][63 - ((m - 1) % 64)];
        return {!pend_full, 1'((n / CLK_DIV) % 2), k >= 32, d, m_fs, m_ur};
    endfunction

    always @(negedge clk) begin
        logic [5:0] got;
        logic [5:0] want;
        got  = {ready, bck, lrck, data, fs, ur};
        want = expect_out();
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL model t=%0t {rdy,bck,lrck,dat,fs,ur} got %b want %b",
                     $time, got, want);
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic send(input logic [SW-1:0] l, input logic [SW-1:0] r);
        bit got;
        got   = 1'b0;
        sl    = l;
        sr    = r;
        valid = 1'b1;
        for (int i = 0; i < 700 && !got; i++) begin
            @(negedge clk);
            if (ready) got = 1'b1;
        end
        @(posedge clk);
        #2;
        valid = 1'b0;
        check("send_accepted", 64'(got), 64'd1);
    endtask

    task automatic wait_fs();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 700 && !ok; i++) begin
            @(negedge clk);
            if (fs) ok = 1'b1;
        end
        check("frame_start_seen", 64'(ok), 64'd1);
    endtask

    task automatic wait_k(input int k);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 700 && !ok; i++) begin
            @(negedge clk);
            if (running && model_k() == k) ok = 1'b1;
        end
        check("reach_bit_cnt", 64'(ok), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [SW-1:0] l;
        logic [SW-1:0] r;
        logic [63:0]   dw;
        logic [63:0]   lw;
        logic          prevb;
        logic          plr;
        logic          pr;
        logic          dor;
        logic [5:0]    ior;
        bit            a;
        bit            ok;
        int            fsc, urc, lre, rises, t2, t3, fsn, acc, urn;

        reset  = 1'b1;
        locked = 1'b0;
        valid  = 1'b0;
        sl     = '0;
        sr     = '0;
        repeat (5) @(posedge clk);
        #2;
        check("reset_outputs", 64'({ready, bck, lrck, data, fs, ur}), 64'd0);
        reset = 1'b0;

        ior = '0;
        repeat (100) begin
            @(negedge clk);
            ior = ior | {ready, bck, lrck, data, fs, ur};
        end
        check("unlocked_quiet", 64'(ior), 64'd0);

        @(posedge clk);
        #2;
        locked = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_lock", 64'(ready), 64'd1);
        @(negedge clk);
        check("bck_before_div", 64'(bck), 64'd0);
        @(negedge clk);
        check("first_bck_toggle", 64'(bck), 64'd1);

        // three frames with nothing offered
        fsc = 0; urc = 0; lre = 0; dor = 1'b0; plr = lrck;
        repeat (800) begin
            @(negedge clk);
            if (fs) fsc++;
            if (ur) urc++;
            dor = dor | data;
            if (lrck != plr) lre++;
            plr = lrck;
        end
        check("underrun_count", 64'(urc), 64'd3);
        check("underrun_frame_starts", 64'(fsc), 64'd3);
        check("underrun_data_zero", 64'(dor), 64'd0);
        check("underrun_lrck_edges", 64'(lre), 64'd6);

        // bit-exact frame
        send(24'h800001, 24'h7FFFFE);
        wait_fs();
        check("bitexact_no_underrun", 64'(ur), 64'd0);
        check("model_pack", frames[frames.size() - 1],
              64'h80000100_7FFFFE00);
        rises = 0; t2 = 0; t3 = 0; prevb = bck; dw = '0; lw = '0;
        for (int i = 0; i < 400 && rises < 65; i++) begin
            @(negedge clk);
            if (bck && !prevb) begin
                rises++;
                if (rises >= 2) begin
                    dw = {dw[62:0], data};
                    lw = {lw[62:0], lrck};
                end
                if (rises == 2) t2 = i;
                if (rises == 3) t3 = i;
            end
            prevb = bck;
        end
        check("capture_rises", 64'(rises), 64'd65);
        check("bck_period", 64'(t3 - t2), 64'd4);
        check("frame_bits", dw, 64'h80000100_7FFFFE00);
        check("lrck_bits", lw, 64'h00000001_FFFFFFFE);

        // back-pressure: valid held, incrementing pairs
        @(posedge clk);
        #2;
        l = 24'($urandom);
        r = l + 24'd1000;
        sl = l; sr = r; valid = 1'b1;
        fsn = 0; acc = 0; urn = 0; pr = ready;
        for (int i = 0; i < 2000 && fsn < 5; i++) begin
            @(negedge clk);
            if (fs) begin
                fsn++;
                check("deferred_accept", 64'({pr, ready}), 64'b01);
            end
            if (ur) urn++;
            a = valid && ready;
            if (a) acc++;
            pr = ready;
            @(posedge clk);
            #2;
            if (a) begin
                l++;
                r++;
                sl = l;
                sr = r;
            end
        end
        valid = 1'b0;
        check("bp_frames", 64'(fsn), 64'd5);
        check("bp_one_per_frame", 64'(acc), 64'(fsn + 1));
        check("bp_no_underrun", 64'(urn), 64'd0);

        // random offers
        repeat (1024) begin
            @(posedge clk);
            #2;
            valid = ($urandom_range(0, 2) == 0);
            sl    = 24'($urandom);
            sr    = 24'($urandom);
        end
        @(posedge clk);
        #2;
        valid = 1'b0;

        // lock loss at bit_cnt 40 with the holding register full
        wait_k(30);
        send(24'h123456, 24'hABCDEF);
        wait_k(40);
        @(posedge clk);
        #2;
        locked = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("lockloss_quiet", 64'({ready, bck, lrck, data, fs, ur}), 64'd0);
        repeat (10) @(posedge clk);
        #2;
        locked = 1'b1;
        wait_fs();
        check("lockloss_flushed", 64'(ur), 64'd1);
        check("lockloss_lrck_left", 64'(lrck), 64'd0);

        // async reset mid-frame, between clock edges
        ok = 1'b0;
        for (int i = 0; i < 700 && !ok; i++) begin
            @(negedge clk);
            if (bck && lrck) ok = 1'b1;
        end
        check("reach_right_half", 64'(ok), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_quiet", 64'({ready, bck, lrck, data, fs, ur}), 64'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_reset", 64'(ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        check("bck_after_reset", 64'(bck), 64'd1);
        send(24'(~$urandom), 24'($urandom));
        wait_fs();
        check("reset_first_frame_loaded", 64'(ur), 64'd0);
        repeat (300) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
